valid_stream_to_ready_fifo: RTL

- Downstream stage for valid-only pipelines, such as a shift register with valid or a formula pipe.
- Captures every transfer marked by in_vld. Upstream has no backpressure, so captures are unconditional.
- Stores transfers in a small circular FIFO and presents them on a valid/ready interface, so a consumer can stall.
- Drops a transfer that arrives while the FIFO is full and cannot drain, and raises a sticky overflow flag.

---
 rtl/valid_stream_to_ready_fifo.sv | 82 ++++++++
 1 files changed

// File: rtl/valid_stream_to_ready_fifo.sv
// valid_stream_to_ready_fifo: captures every in_vld transfer from a valid-only
// pipeline into a small circular FIFO and re-presents it on a valid/ready port.
// Ports: clk/rst (async active-high); in_vld/in_data upstream (no ready);
//   out_vld/out_ready/out_data downstream; full/empty/count status; overflow sticky.
// Latency 1 cycle from in_vld to out_vld (no bypass); drops on full without pop.
module valid_stream_to_ready_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic [width-1:0]           in_data,
  output logic                       out_vld,
  input  logic                       out_ready,
  output logic [width-1:0]           out_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow
);

  localparam int pw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);
  localparam logic [cw-1:0] count_max = cw'(depth);

  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("depth must be a power of two and at least 2");
  end

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic             push_req;
  logic             pop;
  logic             push;

  // Status decodes come only from registered count, so no input reaches
  // full/empty/out_vld combinationally.
  assign empty    = (count == '0);
  assign full     = (count == count_max);
  assign out_vld  = ~empty;
  assign out_data = mem[rd_ptr];

  assign push_req = in_vld;
  assign pop      = out_vld & out_ready;
  // At full, a simultaneous pop frees the slot the write lands in.
  assign push     = push_req & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;  // pointers wrap naturally at depth
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req & ~push) overflow <= 1'b1;
    end
  end

  // Storage is intentionally not reset; out_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (count <= count_max);
      assert (!(pop && count == '0));
      assert (!(push && !pop && count == count_max));
      if (in_vld) assert (!$isunknown(in_data));
    end
  end

endmodule
